// File: rtl/string_char_streamer_pkg.sv
// string_char_streamer_pkg: shared string ROM constants and streamer FSM states
package string_char_streamer_pkg;
  localparam int CHAR_WIDTH = 5;
  localparam int STRING_NUM = 7;
  localparam int MAX_CHAR   = 11;
  localparam int SPACE_CODE = 28;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
endpackage

// File: rtl/string_len_finder.sv
// string_len_finder: string length, optionally excluding trailing space characters
module string_len_finder #(
  parameter int CHAR_WIDTH = string_char_streamer_pkg::CHAR_WIDTH,
  parameter int MAX_CHAR   = string_char_streamer_pkg::MAX_CHAR,
  parameter int SPACE_CODE = string_char_streamer_pkg::SPACE_CODE,
  parameter int LW         = $clog2(MAX_CHAR + 1)
) (
  input  logic [CHAR_WIDTH*MAX_CHAR-1:0] data,
  input  logic                           trim,
  output logic [LW-1:0]                  len
);
  always_comb begin
    len = trim ? '0 : LW'(MAX_CHAR);
    for (int i = 0; i < MAX_CHAR; i++)
      if (trim && data[(MAX_CHAR-1-i)*CHAR_WIDTH +: CHAR_WIDTH] != CHAR_WIDTH'(SPACE_CODE))
        len = LW'(i + 1);
  end
endmodule

// File: rtl/string_char_streamer.sv
// string_char_streamer: streams one ROM string per request, one character per handshake
module string_char_streamer #(
  parameter int CHAR_WIDTH = string_char_streamer_pkg::CHAR_WIDTH,
  parameter int STRING_NUM = string_char_streamer_pkg::STRING_NUM,
  parameter int MAX_CHAR   = string_char_streamer_pkg::MAX_CHAR,
  parameter int SPACE_CODE = string_char_streamer_pkg::SPACE_CODE
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [$clog2(STRING_NUM+1)-1:0]    req_addr,
  input  logic                               trim_en,
  output logic [$clog2(STRING_NUM+1)-1:0]    rom_addr,
  input  logic [CHAR_WIDTH*MAX_CHAR-1:0]     rom_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CHAR_WIDTH-1:0]              out_char,
  output logic [$clog2(MAX_CHAR)-1:0]        out_idx,
  output logic                               out_last,
  output logic                               done,
  output logic                               err
);
  import string_char_streamer_pkg::*;
  localparam int AW = $clog2(STRING_NUM + 1);
  localparam int IW = $clog2(MAX_CHAR);
  localparam int LW = $clog2(MAX_CHAR + 1);
  localparam int DW = CHAR_WIDTH * MAX_CHAR;
  state_t state, state_n;
  logic [DW-1:0] sbuf, sbuf_n;
  logic [LW-1:0] len_q, len_n, len_c;
  logic trim_q, trim_n;
  logic [AW-1:0] rom_addr_n;
  logic [IW-1:0] idx_n, nxt;
  logic valid_n, last_n, done_n, err_n, accept, bad, hit;
  string_len_finder #(
    .CHAR_WIDTH(CHAR_WIDTH), .MAX_CHAR(MAX_CHAR), .SPACE_CODE(SPACE_CODE), .LW(LW)
  ) u_len (
    .data(rom_data), .trim(trim_q), .len(len_c)
  );
  assign req_ready = state == IDLE;
  assign accept    = req_valid & req_ready;
  assign bad       = req_addr >= AW'(STRING_NUM);
  assign hit       = out_valid & out_ready;
  assign nxt       = out_idx + 1'b1;
  assign out_char  = sbuf[DW-1 -: CHAR_WIDTH];
  always_comb begin
    state_n    = state;
    sbuf_n     = sbuf;
    len_n      = len_q;
    trim_n     = trim_q;
    rom_addr_n = rom_addr;
    idx_n      = out_idx;
    valid_n    = out_valid;
    last_n     = out_last;
    done_n     = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: if (accept) begin
        err_n      = bad;
        done_n     = bad;
        state_n    = bad ? IDLE : LOAD;
        rom_addr_n = bad ? rom_addr : req_addr;
        trim_n     = bad ? trim_q : trim_en;
      end
      LOAD: begin
        sbuf_n  = rom_data;
        len_n   = len_c;
        idx_n   = '0;
        valid_n = len_c != '0;
        last_n  = len_c == LW'(1);
        done_n  = len_c == '0;
        state_n = len_c == '0 ? IDLE : STREAM;
      end
      STREAM: if (hit) begin
        valid_n = !out_last;
        done_n  = out_last;
        state_n = out_last ? IDLE : STREAM;
        idx_n   = out_last ? out_idx : nxt;
        sbuf_n  = out_last ? sbuf : sbuf << CHAR_WIDTH;
        last_n  = !out_last && LW'(nxt) + LW'(1) == len_q;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      sbuf      <= '0;
      len_q     <= '0;
      trim_q    <= 1'b0;
      rom_addr  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      sbuf      <= sbuf_n;
      len_q     <= len_n;
      trim_q    <= trim_n;
      rom_addr  <= rom_addr_n;
      out_idx   <= idx_n;
      out_valid <= valid_n;
      out_last  <= last_n;
      done      <= done_n;
      err       <= err_n;
    end
endmodule

// File: tb/tb_string_char_streamer.sv
// tb_string_char_streamer: directed self-checking bench for string_char_streamer
module tb_string_char_streamer;
  logic clk = 0, rst = 1, req_valid = 0, trim_en = 0, out_ready = 1;
  logic req_ready, out_valid, out_last, done, err;
  logic [2:0] req_addr = '0, rom_addr;
  logic [54:0] rom_data;
  logic [54:0] rom [8];
  logic [4:0] out_char;
  logic [3:0] out_idx;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];
  string_char_streamer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .trim_en(trim_en), .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_char(out_char), .out_idx(out_idx), .out_last(out_last),
    .done(done), .err(err)
  );
  function automatic logic [54:0] pk(input string s);
    logic [54:0] r;
    byte c;
    r = '0;
    for (int i = 0; i < 11; i++) begin
      c = i < s.len() ? s[i] : 8'h20;
      r[(10-i)*5 +: 5] = c == 8'h20 ? 5'd28 : c == 8'h3A ? 5'd26 : 5'(c - 8'h41);
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic req(input logic [2:0] a, input logic t);
    req_valid = 1; req_addr = a; trim_en = t;
    chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 0;
  endtask
  task automatic stream(input logic [54:0] s, input int n);
    chk("load_no_valid", out_valid, 0);
    tick();
    for (int i = 0; i < n; i++) begin
      chk("valid", out_valid, 1);
      chk("char", out_char, s[(10-i)*5 +: 5]);
      chk("idx", out_idx, i);
      chk("last", out_last, i == n - 1);
      chk("no_done", done, 0);
      tick();
    end
    chk("done", done, 1);
    chk("valid_end", out_valid, 0);
    chk("ready_end", req_ready, 1);
  endtask
  initial begin
    int exp0 [11];
    logic [3:0] pat;
    int k;
    exp0 = '{6, 0, 12, 4, 28, 19, 8, 12, 4, 26, 28};
    pat = 4'b1001;
    rom[0] = pk("GAME TIME: ");
    rom[1] = pk("HELLO");
    rom[2] = pk("PLAYER ONE");
    rom[3] = pk("SCORE:");
    rom[4] = pk("LEVEL UP");
    rom[5] = pk("");
    rom[6] = pk("WIN");
    rom[7] = '0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_char", out_char, 0);
    chk("rst_ready", req_ready, 1);
    tick();
    rst = 0;
    tick();
    req(0, 0);
    chk("rom_addr0", rom_addr, 0);
    chk("load_no_valid0", out_valid, 0);
    tick();
    for (int i = 0; i < 11; i++) begin
      chk("game_char", out_char, exp0[i]);
      chk("game_idx", out_idx, i);
      chk("game_last", out_last, i == 10);
      chk("game_valid", out_valid, 1);
      tick();
    end
    chk("game_done", done, 1);
    chk("game_end_valid", out_valid, 0);
    tick();
    chk("done_pulse", done, 0);
    req(0, 1);
    stream(pk("GAME TIME:"), 10);
    tick();
    req(7, 0);
    chk("bad_err", err, 1);
    chk("bad_done", done, 1);
    chk("bad_ready", req_ready, 1);
    chk("bad_valid", out_valid, 0);
    tick();
    chk("bad_err_clr", err, 0);
    chk("bad_done_clr", done, 0);
    chk("bad_valid2", out_valid, 0);
    req(5, 1);
    chk("empty_load", out_valid, 0);
    tick();
    chk("empty_done", done, 1);
    chk("empty_valid", out_valid, 0);
    chk("empty_ready", req_ready, 1);
    tick();
    req(1, 1);
    tick();
    k = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      out_ready = pat[c % 4];
      chk("bp_valid", out_valid, 1);
      chk("bp_char", out_char, rom[1][(10-k)*5 +: 5]);
      chk("bp_idx", out_idx, k);
      chk("bp_last", out_last, k == 4);
      tick();
      if (out_ready) k++;
    end
    chk("bp_count", k, 5);
    chk("bp_done", done, 1);
    out_ready = 1;
    tick();
    req(0, 0);
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_idx", out_idx, 4);
    rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_char", out_char, 0);
    chk("arst_last", out_last, 0);
    chk("arst_ready", req_ready, 1);
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk("arst_no_done", done, 0);
      chk("arst_idle", out_valid, 0);
      tick();
    end
    req(0, 0);
    stream(rom[0], 11);
    tick();
    req(6, 0);
    stream(rom[6], 11);
    req(1, 1);
    stream(rom[1], 5);
    tick();
    chk("final_done_clr", done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/string_char_streamer.md
STRING_CHAR_STREAMER -- requirements
Module: string_char_streamer

Interface
REQ-001 The module SHALL have parameter CHAR_WIDTH, default 5, meaning bits per character code.
REQ-002 The module SHALL have parameter STRING_NUM, default 7, meaning number of strings in the string ROM.
REQ-003 The module SHALL have parameter MAX_CHAR, default 11, meaning characters per ROM string.
REQ-004 The module SHALL have parameter SPACE_CODE, default 28, meaning the space character code.
REQ-005 The module SHALL use one clock and an asynchronous, active-high reset, as fixed below.
REQ-006 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port req_valid, input, 1 bit: string request present.
REQ-009 Port req_ready, output, 1 bit: request accepted this cycle if req_valid=1.
REQ-010 Port req_addr, input, clog2(STRING_NUM+1) bits: string index.
REQ-011 Port trim_en, input, 1 bit: sampled with the request; suppresses trailing spaces.
REQ-012 Port rom_addr, output, clog2(STRING_NUM+1) bits: registered address to the combinational string ROM.
REQ-013 Port rom_data, input, CHAR_WIDTH*MAX_CHAR bits: ROM string; char i at bits [(MAX_CHAR-1-i)*CHAR_WIDTH +: CHAR_WIDTH], so char 0 is MSB.
REQ-014 Port out_valid, output, 1 bit: character available.
REQ-015 Port out_ready, input, 1 bit: consumer accepts the character.
REQ-016 Port out_char, output, CHAR_WIDTH bits: character code.
REQ-017 Port out_idx, output, clog2(MAX_CHAR) bits: character position.
REQ-018 Port out_last, output, 1 bit: final character of the string.
REQ-019 Port done, output, 1 bit: one-cycle pulse at end of request.
REQ-020 Port err, output, 1 bit: one-cycle pulse when req_addr >= STRING_NUM.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD and STREAM.
REQ-022 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-023 When req_valid & req_ready and req_addr < STRING_NUM: register rom_addr and trim_en, then go to LOAD.
REQ-024 When req_valid & req_ready and req_addr >= STRING_NUM: pulse err and done next cycle, stay in IDLE, emit nothing.
REQ-025 LOAD SHALL last one cycle: latch rom_data into a buffer, compute length len, set idx=0.
REQ-026 len SHALL be MAX_CHAR when trim=0; otherwise it SHALL be 1 plus the position of the last non-SPACE_CODE char.
REQ-027 If len=0 (all spaces, trim=1), the block SHALL pulse done and return to IDLE with no output.
REQ-028 In STREAM, out_valid SHALL be 1, with out_char = buffer char idx and out_idx = idx.
REQ-029 In STREAM, out_last SHALL equal (idx == len-1).
REQ-030 out_char, out_idx and out_last SHALL hold stable while out_valid & !out_ready.
REQ-031 On out_valid & out_ready: if not last, idx SHALL increment; if last, pulse done and go to IDLE.
REQ-032 The first character SHALL appear 2 cycles after request acceptance; 1 char/cycle with out_ready held high.
REQ-033 A new request SHALL be acceptable in the cycle after done (IDLE); back-to-back gap is 1 cycle.
REQ-034 Outputs SHALL be registered; no combinational path from out_ready to out_valid.

Reset
REQ-035 On rst=1, the FSM SHALL go to IDLE, and rom_addr, idx, buffer, out_valid, out_last, done and err SHALL all be 0.
REQ-036 Reset mid-STREAM SHALL abort the string, with no done pulse.

Structure
REQ-037 CHAR_WIDTH, MAX_CHAR, STRING_NUM and SPACE_CODE SHALL live in the shared project constants package/header used with the string ROM.
REQ-038 Trailing-space length computation SHALL be one combinational sub-module, string_len_finder.

Verification
REQ-039 Addr 0 ("GAME TIME: "), trim=0, out_ready=1 -> codes 6,0,12,4,28,19,8,12,4,26,28 on cycles 2..12; out_last on idx 10; done on cycle 13.
REQ-040 Addr 0, trim=1 -> 10 chars ending with 26 at idx 9 carrying out_last.
REQ-041 Addr 7 -> err and done pulse, req_ready stays 1, out_valid never asserts.
REQ-042 Backpressure: out_ready toggles 1,0,0,1 -> each char is held stable while stalled, with no skip or duplicate.
REQ-043 rst asserted at idx 4 -> outputs 0 immediately, IDLE, no done; the next request streams from idx 0.
REQ-044 Back-to-back requests for addr 6 then 1 -> both strings complete, with a 1-cycle IDLE gap between them.
